// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: UART transmitter with built-in baud divider, parity, 1/2 stop bits and ready/valid input.
// Ports:
//   clk_i, rst_i          single clock, synchronous active-high reset
//   baud_div_i            clk cycles per serial bit (0 acts as 1)
//   par_en_i, par_typ_i   parity enable, parity type (0 even, 1 odd)
//   stop2_i               1 selects two stop bits
//   data_valid_i, p_data_i, data_ready_o   word handshake, LSB sent first
//   busy_o, s_data_o, done_o               frame in progress, serial line, end-of-frame pulse
module uart_tx_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    input  logic                  stop2_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    output logic                  data_ready_o,
    output logic                  busy_o,
    output logic                  s_data_o,
    output logic                  done_o
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d, dm1_q, dm1_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d;
    logic                  s_data_d, busy_d, done_d;
    logic                  last, final_stop, accept;
    always_comb begin
        last         = div_q == dm1_q;
        final_stop   = state_q == STOP && last && bit_q == BW'(stop2_q);
        data_ready_o = !rst_i && (state_q == IDLE || final_stop);
        accept       = data_valid_i && data_ready_o;
        state_d      = state_q;
        div_d        = last ? '0 : div_q + DIV_WIDTH'(1);
        bit_d        = bit_q;
        data_d       = data_q;
        dm1_d        = dm1_q;
        par_en_d     = par_en_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        case (state_q)
            IDLE:   div_d = '0;
            START:  state_d = last ? DATA : START;
            DATA: begin
                if (last) begin
                    data_d = data_q >> 1;
                    bit_d  = (bit_q == BW'(DATA_WIDTH - 1)) ? '0 : bit_q + BW'(1);
                    if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: state_d = last ? STOP : PARITY;
            STOP: begin
                if (last) begin
                    bit_d   = final_stop ? '0 : bit_q + BW'(1);
                    state_d = final_stop ? IDLE : STOP;
                end
            end
            default: state_d = IDLE;
        endcase
        // Acceptance overrides the STOP->IDLE exit so frames can run back to back.
        if (accept) begin
            state_d  = START;
            div_d    = '0;
            bit_d    = '0;
            data_d   = p_data_i;
            dm1_d    = (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);
            par_en_d = par_en_i;
            par_d    = par_typ_i ? ~^p_data_i : ^p_data_i;
            stop2_d  = stop2_i;
        end
        // Registered outputs are decoded from the next state so they line up with it.
        s_data_d = state_d == START ? 1'b0 : state_d == DATA ? data_d[0] : state_d == PARITY ? par_d : 1'b1;
        busy_d   = state_d != IDLE;
        done_d   = state_d == STOP && div_d == dm1_d && bit_d == BW'(stop2_d);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            dm1_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            s_data_o <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            dm1_q    <= dm1_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            s_data_o <= s_data_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2: scoreboard bench for an 8-bit and a 5-bit uart_tx_gen2 instance.
module tb_uart_tx_gen2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mon_en = 1'b0;
    logic        rst_at_edge = 1'b1;
    logic [1:0]  valid = '0, pe = '0, pt = '0, s2 = '0;
    logic [8:0]  pdata [2];
    logic [15:0] baud [2];
    logic [1:0]  ready, busy_w, sd, done_w;
    logic [1:0]  q0[$], q1[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_at_edge <= rst;

    uart_tx_gen2 #(.DATA_WIDTH(8), .DIV_WIDTH(16)) u8 (
        .clk_i(clk), .rst_i(rst), .baud_div_i(baud[0]), .par_en_i(pe[0]), .par_typ_i(pt[0]),
        .stop2_i(s2[0]), .data_valid_i(valid[0]), .p_data_i(pdata[0][7:0]),
        .data_ready_o(ready[0]), .busy_o(busy_w[0]), .s_data_o(sd[0]), .done_o(done_w[0]));

    uart_tx_gen2 #(.DATA_WIDTH(5), .DIV_WIDTH(16)) u5 (
        .clk_i(clk), .rst_i(rst), .baud_div_i(baud[1]), .par_en_i(pe[1]), .par_typ_i(pt[1]),
        .stop2_i(s2[1]), .data_valid_i(valid[1]), .p_data_i(pdata[1][4:0]),
        .data_ready_o(ready[1]), .busy_o(busy_w[1]), .s_data_o(sd[1]), .done_o(done_w[1]));

    // Expected line waveform: one entry per clk cycle, {line level, last cycle of frame}.
    task automatic push_frame(int k, int w, logic [8:0] d, int bd, bit p_en, bit p_typ, bit two);
        int   dd = (bd == 0) ? 1 : bd;
        bit   bits[$];
        bit   p = p_typ;
        logic [1:0] e;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(d[i]);
            p ^= d[i];
        end
        if (p_en) bits.push_back(p);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int j = 0; j < dd; j++) begin
                e = {bits[i], (i == bits.size() - 1 && j == dd - 1)};
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
    endtask

    task automatic send(int k, logic [8:0] d, int bd, bit p_en, bit p_typ, bit two);
        bit ok = 0;
        valid[k] = 1'b1; pdata[k] = d; baud[k] = 16'(bd);
        pe[k] = p_en; pt[k] = p_typ; s2[k] = two;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                @(posedge clk);
                push_frame(k, (k == 0) ? 8 : 5, d, bd, p_en, p_typ, two);
                ok = 1;
                #1;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout inst%0d ready=%b required 1 within 500 cycles", k, ready[k]);
        end
    endtask

    task automatic idle(int k, int n);
        valid[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] got, exp;
                logic [1:0] e;
                got = {sd[k], busy_w[k], done_w[k], ready[k]};
                if (rst_at_edge) begin
                    if (k == 0) q0.delete(); else q1.delete();
                    exp = {1'b1, 1'b0, 1'b0, !rst};
                end else if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    exp = {e[1], 1'b1, e[0], e[0] & !rst};
                end else
                    exp = {1'b1, 1'b0, 1'b0, !rst};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL line inst%0d t=%0t s/busy/done/ready got %b required %b", k, $time, got, exp);
                end
            end
        end
    end

    initial begin
        bit ok;
        pdata[0] = '0; pdata[1] = '0; baud[0] = '0; baud[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mon_en = 1'b1;
        idle(0, 2);
        send(0, 9'hA5, 4, 0, 0, 0); idle(0, 3);
        send(0, 9'h07, 2, 1, 0, 0); send(0, 9'h07, 2, 1, 1, 0); idle(0, 2);
        send(0, 9'h00, 3, 0, 0, 1); send(0, 9'hFF, 3, 0, 0, 1); idle(0, 1);
        send(0, 9'h3C, 0, 0, 0, 0);
        baud[0] = 16'd5; pe[0] = 1'b1; valid[0] = 1'b0;
        idle(0, 3);
        send(0, 9'h3C, 5, 1, 0, 0); idle(0, 1);
        send(0, 9'hC3, 4, 0, 0, 0); idle(0, 12);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(0, 4);
        for (int i = 0; i < 30; i++) begin
            send(0, 9'($urandom_range(0, 255)), $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(0, 6));
        end
        idle(0, 1);
        send(1, 9'h13, 1, 1, 1, 0); idle(1, 2);
        for (int i = 0; i < 20; i++) begin
            send(1, 9'($urandom_range(0, 31)), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(1, $urandom_range(0, 4));
        end
        idle(1, 1);
        ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = q0.size() == 0 && q1.size() == 0;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (!ok || busy_w !== 2'b00) begin
            errors++;
            $display("FAIL drain busy got %b required 00, pending %0d/%0d", busy_w, q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_gen2.md
# uart_tx_gen2

Parametrised next-generation UART transmitter with a built-in baud divider, configurable character width, optional even/odd parity, one or two stop bits, and a ready/valid input handshake. It supports zero-gap back-to-back frames. It takes the TX-side place of the UART pair: a FIFO or register file feeds it parallel words, and it drives the serial line. Everything runs on one clock, so no external baud clock is needed.

## Interface
- DATA_WIDTH, 8, character width in bits; legal range 5..9.
- DIV_WIDTH, 16, width of the baud-divider configuration and counter.

- CLK  in  1  single system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- BAUD_DIV  in  DIV_WIDTH  CLK cycles per serial bit; 0 is treated as 1.
- PAR_EN  in  1  1 = append parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits, 0 = one.
- DATA_VALID  in  1  P_DATA holds a word to send.
- P_DATA  in  DATA_WIDTH  parallel word, sent LSB first.
- DATA_READY  out  1  the block accepts P_DATA this cycle.
- busy  out  1  a frame is in progress.
- S_DATA  out  1  serial line; idle-high.
- DONE  out  1  one-cycle pulse in the last CLK cycle of a frame.

## Operation
- **States:**
  - IDLE
  - START (1 bit)
  - DATA (DATA_WIDTH bits)
  - PARITY (1 bit, only if PAR_EN)
  - STOP (1 or 2 bits)
- **Bit timing:** every serial bit lasts exactly D = max(BAUD_DIV,1) CLK cycles, counted by a divider counter that is cleared on each bit boundary.
- **Handshake:** a word transfers on the rising edge where DATA_VALID && DATA_READY.
  - DATA_READY = !RST && (state==IDLE || (state==STOP && final cycle of final stop bit)).
- **Captured at acceptance:** P_DATA, BAUD_DIV, PAR_EN, PAR_TYP and STOP2 are registered when a word is accepted. Changes to these inputs mid-frame have no effect on the current frame.
- **Transitions:**
  - IDLE→START on accept.
  - START→DATA after D cycles.
  - DATA→PARITY (PAR_EN=1) or →STOP (PAR_EN=0) after DATA_WIDTH·D cycles.
  - PARITY→STOP after D cycles.
  - STOP→START if a word is accepted in its final cycle; otherwise STOP→IDLE.
- **Parity bit:**
  - Even (PAR_TYP=0): ^data.
  - Odd (PAR_TYP=1): ~^data.
  - Computed over the DATA_WIDTH captured bits.
- **Frame length:** (1 + DATA_WIDTH + PAR_EN + 1 + STOP2)·D cycles.
- **Line levels:** S_DATA is 0 in START, data bit i in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
- **busy:** high in every non-IDLE state, and stays high continuously across back-to-back frames.
- **DONE:** high in the final cycle of the final stop bit, whether or not a new word is accepted in that cycle.
- **Internal widths:**
  - Bit-index counter: clog2(DATA_WIDTH+1) bits.
  - Divider: DIV_WIDTH bits, compared against D−1; no wrap inside a bit.

## Timing
- **Reset values** (on the first edge with RST=1):
  - state=IDLE
  - S_DATA=1
  - busy=0
  - DONE=0
  - DATA_READY=0 while RST is high
  - all counters 0
- **Reset mid-frame:** the frame aborts at the next edge and the line returns high immediately. No DONE pulse is produced.
- **All outputs are registered except DATA_READY**, which is decoded from registered state.
- **Latency:** an accept at edge t (S_DATA is driven from a register) gives:
  - S_DATA=0 and busy=1 from t to t+D.
  - First data bit on S_DATA from edge t+D.
- **Back-to-back streaming:** with DATA_VALID held high, the next start bit directly follows the last stop bit with zero idle cycles. The frame period is exactly the frame length.
- **DATA_VALID deasserted in the final stop cycle:** the block goes to IDLE, S_DATA=1, busy=0 on the next edge, and DATA_READY=1 from that cycle onward.
- **D=1 (BAUD_DIV 0 or 1):** one bit per CLK and all transitions still hold. DONE and DATA_READY coincide with the single stop-bit cycle.
- **DATA_VALID while DATA_READY=0:** ignored. P_DATA must be held by the source until it is accepted.

## Test plan
- **Reset:**
  - Stimulus: RST high for 3 cycles in the middle of a DATA bit, then released.
  - Required: S_DATA=1, busy=0, DONE=0 after the first reset edge; DATA_READY=1 in the first cycle after release; no partial frame resumes.
- **Basic frame:**
  - Stimulus: DATA_WIDTH=8, BAUD_DIV=4, PAR_EN=0, STOP2=0, P_DATA=8'hA5.
  - Required: S_DATA = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles (40 cycles total); DONE pulses in cycle 40 after accept; busy drops the next cycle.
- **Parity:**
  - Stimulus: BAUD_DIV=2, PAR_EN=1, P_DATA=8'h07.
  - Required: parity bit=1 with PAR_TYP=0 and 0 with PAR_TYP=1; frame length is 22 cycles.
- **Back-to-back with STOP2:**
  - Stimulus: STOP2=1, BAUD_DIV=3, DATA_VALID held high with 8'h00 then 8'hFF.
  - Required: each frame is 33 cycles; the second start bit immediately follows the 6-cycle stop high; busy stays high for 66 cycles; exactly two DONE pulses.
- **Config capture / D=1:**
  - Stimulus: send a frame with BAUD_DIV=0, changing BAUD_DIV to 5 and PAR_EN to 1 mid-frame.
  - Required: the frame is 10 cycles at 1 bit/cycle with no parity; the next frame uses D=5 with parity.
- **Narrow instance:**
  - Stimulus: DATA_WIDTH=5, PAR_EN=1, PAR_TYP=1, P_DATA=5'h13, BAUD_DIV=1.
  - Required: S_DATA = 0,1,1,0,0,1,0,1, which is 8 cycles with parity bit=0.
